// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkg
// Description : Shared types and constants for the SD card block datapath
//               (block writer today, block reader state enum later).
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

   // Bytes in one SD data block; fixed by the card protocol.
   localparam int SD_BLOCK_BYTES = 512;

   // Width of the per-block byte counter; must hold SD_BLOCK_BYTES itself.
   localparam int SD_BYTE_CNT_W = 10;

   // Block writer sequencing states.
   typedef enum logic [2:0] {
      SD_WR_IDLE       = 3'd0,
      SD_WR_WAIT_READY = 3'd1,
      SD_WR_ISSUE      = 3'd2,
      SD_WR_STREAM     = 3'd3,
      SD_WR_DRAIN      = 3'd4
   } sd_wr_state_t;

endpackage
`default_nettype wire

// File: rtl/sd_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sd_byte_fifo
// Description : Single-clock byte FIFO with show-ahead read data. Pointers
//               carry one extra wrap bit so full and empty are distinguishable
//               without a separate counter. Contents are not reset; emptying
//               the pointers discards them.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      wr_ptr_d;
   logic [AW:0]      rd_ptr_q;
   logic [AW:0]      rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Status flags, qualified handshakes and next pointer values.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      count    = wr_ptr_q - rd_ptr_q;
      rdata    = mem_q[rd_ptr_q[AW-1:0]];
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; written only on an accepted push.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sd_block_writer.sv
`default_nettype none
// ============================================================================
// Module      : sd_block_writer
// Description : Buffers an upstream byte stream and feeds exactly one
//               512-byte block per write_signal to the shared sd_controller
//               through its wr / din / ready_for_next_byte handshake. Pads
//               with PAD_BYTE when the buffer runs dry and flags underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_block_writer
   import sd_pkg::*;
#(
   parameter int         FIFO_DEPTH  = 16,
   parameter logic [7:0] PAD_BYTE    = 8'h00,
   parameter int         BLOCK_BYTES = SD_BLOCK_BYTES
) (
   input  logic        clk_25mhz,
   input  logic        rst_n,
   input  logic        write_signal,
   input  logic [31:0] address,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sd_ready,
   input  logic        sd_ready_for_next_byte,
   output logic        sd_wr,
   output logic [7:0]  sd_din,
   output logic [31:0] sd_address,
   output logic        busy,
   output logic        done,
   output logic        underrun
);

   localparam int                      FIFO_AW   = $clog2(FIFO_DEPTH);
   localparam logic [SD_BYTE_CNT_W-1:0] BLOCK_CNT = SD_BYTE_CNT_W'(BLOCK_BYTES);
   localparam logic [SD_BYTE_CNT_W-1:0] LAST_IDX  = SD_BYTE_CNT_W'(BLOCK_BYTES - 1);

   // ---------------------------------------------------------------------
   // Byte buffer
   // ---------------------------------------------------------------------
   logic [7:0]       fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic [FIFO_AW:0] fifo_count;
   logic             fifo_pop;
   logic             fifo_has_byte;

   sd_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk_25mhz),
      .rst_n (rst_n),
      .push  (in_valid),
      .wdata (in_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ---------------------------------------------------------------------
   // Sequencer state
   // ---------------------------------------------------------------------
   sd_wr_state_t             state_q,      state_d;
   logic [SD_BYTE_CNT_W-1:0] byte_count_q, byte_count_d;
   logic [7:0]               sd_din_q,     sd_din_d;
   logic [31:0]              sd_address_q, sd_address_d;
   logic                     sd_wr_q,      sd_wr_d;
   logic                     busy_q,       busy_d;
   logic                     done_q,       done_d;
   logic                     underrun_q,   underrun_d;
   logic                     rfnb_prev_q,  rfnb_prev_d;
   logic                     low_seen_q,   low_seen_d;
   logic                     rfnb_rise;
   logic                     load_next;

   // Next-state, byte fetch and output decode for the block sequencer.
   always_comb begin
      state_d       = state_q;
      byte_count_d  = byte_count_q;
      sd_din_d      = sd_din_q;
      sd_address_d  = sd_address_q;
      underrun_d    = underrun_q;
      low_seen_d    = low_seen_q;
      done_d        = 1'b0;
      load_next     = 1'b0;
      fifo_pop      = 1'b0;
      rfnb_prev_d   = sd_ready_for_next_byte;
      rfnb_rise     = sd_ready_for_next_byte && !rfnb_prev_q;
      // The count check mirrors empty; both come from the same pointers.
      fifo_has_byte = !fifo_empty && (fifo_count != '0);

      unique case (state_q)
         SD_WR_IDLE: begin
            if (write_signal) begin
               sd_address_d = address;
               byte_count_d = '0;
               underrun_d   = 1'b0;
               low_seen_d   = 1'b0;
               state_d      = SD_WR_WAIT_READY;
            end
         end

         SD_WR_WAIT_READY: begin
            // Present the first byte before the command so it is stable
            // when the controller first asks for data.
            if (sd_ready) begin
               load_next = 1'b1;
               state_d   = SD_WR_ISSUE;
            end
         end

         SD_WR_ISSUE: begin
            state_d = SD_WR_STREAM;
         end

         SD_WR_STREAM: begin
            // Each request edge consumes the byte currently on sd_din.
            if (rfnb_rise) begin
               byte_count_d = (byte_count_q >= BLOCK_CNT) ?
                              BLOCK_CNT : byte_count_q + SD_BYTE_CNT_W'(1);
               if (byte_count_q < LAST_IDX) begin
                  load_next = 1'b1;
               end else begin
                  state_d = SD_WR_DRAIN;
               end
            end
         end

         SD_WR_DRAIN: begin
            // Controller drops ready while it finishes CRC and response,
            // then raises it again; done is the final DRAIN cycle.
            if (!sd_ready) begin
               low_seen_d = 1'b1;
            end
            if (done_q) begin
               state_d = SD_WR_IDLE;
            end else if (low_seen_q && sd_ready) begin
               done_d = 1'b1;
            end
         end

         default: begin
            state_d = SD_WR_IDLE;
         end
      endcase

      // Fetch the next byte for the controller; an empty buffer yields the
      // pad byte and marks the block as underrun.
      if (load_next) begin
         if (fifo_has_byte) begin
            sd_din_d = fifo_rdata;
            fifo_pop = 1'b1;
         end else begin
            sd_din_d   = PAD_BYTE;
            underrun_d = 1'b1;
         end
      end

      sd_wr_d = (state_d == SD_WR_ISSUE);
      busy_d  = (state_d != SD_WR_IDLE);
   end

   // Sequencer and output registers; reset clears everything at once.
   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SD_WR_IDLE;
         byte_count_q <= '0;
         sd_din_q     <= 8'h00;
         sd_address_q <= 32'h0;
         sd_wr_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
         rfnb_prev_q  <= 1'b0;
         low_seen_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_count_q <= byte_count_d;
         sd_din_q     <= sd_din_d;
         sd_address_q <= sd_address_d;
         sd_wr_q      <= sd_wr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
         rfnb_prev_q  <= rfnb_prev_d;
         low_seen_q   <= low_seen_d;
      end
   end

   // Port drive straight from registers.
   always_comb begin
      in_ready   = !fifo_full;
      sd_wr      = sd_wr_q;
      sd_din     = sd_din_q;
      sd_address = sd_address_q;
      busy       = busy_q;
      done       = done_q;
      underrun   = underrun_q;
   end

endmodule
`default_nettype wire

// File: doc/sd_block_writer.md
# sd_block_writer

Write-direction companion to the SD block reader: collects an upstream byte stream into a small FIFO and feeds one 512-byte block to the shared SPI-mode `sd_controller` through its `wr`/`din`/`ready_for_next_byte` handshake. It sits between the capture/record path and the `sd_controller` instance, which is owned by the top level and shared with the reader. It issues exactly one write command per `write_signal`, pads short blocks, and reports completion and underrun.

## Interface
- `FIFO_DEPTH`, 16: byte FIFO depth; power of two, at least 4.
- `PAD_BYTE`, 8'h00: byte substituted when the FIFO is empty at a byte request.
- `BLOCK_BYTES`, 512: bytes per block; fixed by the SD protocol and not overridden.
- Clock and reset: one clock, `clk_25mhz`; reset is asynchronous and active-low, named `rst_n`.
- `clk_25mhz`  in  1  system clock, 25 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `write_signal`  in  1  pulse or level; starts one block write when sampled in IDLE.
- `address`  in  32  block address; latched on the start cycle.
- `in_data`  in  8  upstream byte.
- `in_valid`  in  1  upstream byte valid.
- `in_ready`  out  1  equals `!fifo_full`; a byte transfers when `in_valid && in_ready`.
- `sd_ready`  in  1  `sd_controller` ready.
- `sd_ready_for_next_byte`  in  1  `sd_controller` byte request (level).
- `sd_wr`  out  1  one-cycle write command pulse.
- `sd_din`  out  8  byte presented to the controller.
- `sd_address`  out  32  latched block address.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the block completes.
- `underrun`  out  1  sticky; set on any pad substitution; cleared on start.

## Operation
- FSM states: IDLE, WAIT_READY, ISSUE, STREAM, DRAIN.
- IDLE
  - If `write_signal` is high: latch `address`, clear `byte_count` and `underrun`, go to WAIT_READY.
  - `write_signal` is ignored in all other states.
- WAIT_READY
  - When `sd_ready` is high, load `sd_din` with the FIFO head (or `PAD_BYTE` if empty, setting `underrun`).
  - Go to ISSUE.
- ISSUE
  - Assert `sd_wr` for exactly one cycle, then go to STREAM.
- STREAM
  - Edge-detect `sd_ready_for_next_byte` with a registered copy.
  - Each rising edge counts the currently presented byte: `byte_count += 1`.
  - If `byte_count` was below 511, load the next `sd_din` from the FIFO (pop), or `PAD_BYTE` with `underrun` set if the FIFO is empty.
  - At the 512th edge go to DRAIN; no pop occurs.
- DRAIN
  - Wait for `sd_ready` low, then high again (controller busy, then CRC/response finished).
  - Then pulse `done` and return to IDLE.
- FIFO accepts pushes in every state, so upstream can preload before start. Bytes beyond 512 remain for the next block.
- Arithmetic: `byte_count` is 10 bits and saturates at 512. The FIFO uses log2(`FIFO_DEPTH`)+1-bit pointers and wraps naturally.

## Timing
- Reset values:
  - `sd_wr` 0, `sd_din` 8'h00, `sd_address` 0.
  - `busy` 0, `done` 0, `underrun` 0.
  - `in_ready` 1, FIFO empty, state IDLE.
- Start latency: `write_signal` high in IDLE with `sd_ready` already high gives `sd_wr` high exactly 2 cycles later.
- Byte update: `sd_din` changes no later than 2 cycles after the `sd_ready_for_next_byte` rising edge. It is stable at all other times. The controller spends at least 16 clocks per byte, which covers this.
- Simultaneous push and pop
  - FIFO not empty: both succeed and the count is unchanged.
  - FIFO empty: the pop takes `PAD_BYTE` and the pushed byte is stored. There is no fall-through.
- Full FIFO: `in_ready` is 0 and the push is dropped by handshake. Same-cycle pop frees the slot only on the next cycle.
- `done` is asserted only in the cycle leaving DRAIN and never coincides with `sd_wr`.
- Reset mid-operation: all state clears immediately and FIFO contents are discarded. `sd_wr` never glitches high.

## Structure
- Package `sd_pkg` holds:
  - `sd_wr_state_t` enum;
  - `SD_BLOCK_BYTES = 512`;
  - `SD_BYTE_CNT_W = 10`.
  - The reader's state enum can migrate there later.
- Sub-module `sd_byte_fifo`: synchronous single-clock FIFO with the same async active-low reset. Ports: push/pop, data in/out, full, empty, count.
- The writer contains only the FSM, edge detect, counter, and output registers. It does not instantiate `sd_controller`.

## Test plan
- Preload 512 bytes 0..255,0..255, pulse `write_signal` with `address`=32'h0000_0040, and have the controller model request 512 bytes → exactly one `sd_wr` pulse, `sd_address`=32'h40, bytes delivered in order, one `done` pulse, `underrun`=0.
- Preload 10 bytes then run a full block → bytes 0..9 delivered, then 502 × 8'h00, `underrun`=1, `done` pulsed.
- Hold `in_valid` high with the FIFO full (16 bytes) → `in_ready`=0, no byte lost or duplicated. Same-cycle push/pop on an empty FIFO → pad taken, pushed byte delivered next.
- Hold `sd_ready` low for 100 cycles after start → no `sd_wr` until `sd_ready` rises. Pulse `write_signal` during STREAM → ignored, still only one `sd_wr`.
- Deassert `rst_n` at byte 200 → outputs return to reset values asynchronously. A fresh start then writes a full clean block.
- Preload 520 bytes → first block takes bytes 0..511, the remaining 8 stay in the FIFO, and a second block starts with byte 512.
